// File: rtl/accumulator_bank.sv
// Bank of DEPTH accumulators on the W bus with load, tri-state readback and a
// small sequencer for in-place inc/dec/clear and multi-cycle shift/rotate.
module accumulator_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int SEL_W = $clog2(DEPTH),
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] ain,
    input  logic             nLa,
    input  logic [SEL_W-1:0] wsel,
    input  logic [SEL_W-1:0] rsel,
    input  logic             nEa,
    input  logic [2:0]       op,
    input  logic             op_go,
    input  logic [AMT_W-1:0] amt,
    output tri   [WIDTH-1:0] aout,
    output logic [WIDTH-1:0] atemp,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for a load or an op_go request
    // SHIFT | shifting/rotating the target one bit per edge until cnt hits 0
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_DEC = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;

    state_t           state;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [SEL_W-1:0] target;
    logic [1:0]       sh_op;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] sh_val;
    logic             sh_c;

    assign atemp = regs[rsel];
    assign zero  = (atemp == '0);
    assign aout  = nEa ? {WIDTH{1'bz}} : atemp;

    // One step of the latched shift/rotate; op[1:0] is SHL, SHR, ROL, ROR.
    always_comb begin
        cur    = regs[target];
        sh_val = cur;
        sh_c   = 1'b0;
        case (sh_op)
            2'b00: begin sh_val = {cur[WIDTH-2:0], 1'b0};       sh_c = cur[WIDTH-1]; end
            2'b01: begin sh_val = {1'b0, cur[WIDTH-1:1]};       sh_c = cur[0];       end
            2'b10: begin sh_val = {cur[WIDTH-2:0], cur[WIDTH-1]}; sh_c = cur[WIDTH-1]; end
            default: begin sh_val = {cur[0], cur[WIDTH-1:1]};   sh_c = cur[0];       end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            state  <= IDLE;
            target <= '0;
            sh_op  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!nLa) begin
                        regs[wsel] <= ain;
                    end else if (op_go && op != OP_NOP) begin
                        target <= wsel;
                        sh_op  <= op[1:0];
                        cnt    <= amt;
                        carry  <= 1'b0;
                        busy   <= 1'b1;
                        case (op)
                            OP_INC: begin
                                regs[wsel] <= regs[wsel] + WIDTH'(1);
                                carry      <= &regs[wsel];
                                state      <= DONE;
                                done       <= 1'b1;
                            end
                            OP_DEC: begin
                                regs[wsel] <= regs[wsel] - WIDTH'(1);
                                carry      <= ~|regs[wsel];
                                state      <= DONE;
                                done       <= 1'b1;
                            end
                            OP_CLR: begin
                                regs[wsel] <= '0;
                                state      <= DONE;
                                done       <= 1'b1;
                            end
                            default: begin
                                if (amt == '0) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    regs[target] <= sh_val;
                    carry        <= sh_c;
                    cnt          <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    // Loads to other registers proceed; the busy target is protected.
                    if (!nLa && wsel != target) regs[wsel] <= ain;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!nLa && wsel != target) regs[wsel] <= ain;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/accumulator_bank.md
# accumulator_bank

Parametrised successor to the single SAP-1 accumulator: a bank of DEPTH accumulator registers of WIDTH bits on the W bus. Each register can be loaded from the bus, driven back onto it through a tri-state output, and presented continuously to the adder/subtractor. A small sequencer adds in-place operations: increment, decrement, clear, and multi-cycle shift/rotate. It reports busy/done handshake, zero and carry flags to the controller.

## Interface
- WIDTH, 8, register and bus width (≥2)
- DEPTH, 2, number of accumulators (power of two, ≥2); SEL_W = $clog2(DEPTH), AMT_W = $clog2(WIDTH)+1 (derived)
- CLK  in  1  system clock, all state changes on rising edge
- CLR  in  1  reset, asynchronous, active-high
- ain  in  WIDTH  data from W bus
- nLa  in  1  active-low load of ain into register wsel
- wsel  in  SEL_W  target register for load and for operations
- rsel  in  SEL_W  register presented on aout/atemp/zero
- nEa  in  1  active-low enable of aout onto W bus
- op  in  3  000 NOP, 001 INC, 010 DEC, 011 CLEAR, 100 SHL, 101 SHR (logical), 110 ROL, 111 ROR
- op_go  in  1  start request, sampled in IDLE only
- amt  in  AMT_W  shift/rotate count, 0..WIDTH
- aout  out  WIDTH  reg[rsel] when nEa=0, else high-Z
- atemp  out  WIDTH  reg[rsel], always driven (to ALU)
- zero  out  1  1 when atemp == 0
- carry  out  1  registered flag of last operation
- busy  out  1  1 whenever state ≠ IDLE
- done  out  1  1 for exactly one cycle in state DONE

## Operation
- Reset (CLR=1, any time, async): all registers 0, carry 0, state IDLE, busy 0, done 0; atemp 0, zero 1, aout high-Z unless nEa=0 (then 0). Reset mid-operation aborts it with no done pulse.
- Load: nLa=0 at an edge writes ain to reg[wsel]; carry unaffected.
- FSM states IDLE, SHIFT, DONE.
- IDLE, op_go=1, op≠NOP, nLa=1: latch target=wsel, op, cnt=amt; clear carry.
  - INC: reg+1 mod 2^WIDTH at this edge; carry=1 iff old value all ones. → DONE.
  - DEC: reg−1 mod 2^WIDTH; carry=1 iff old value 0. → DONE.
  - CLEAR: reg=0, carry=0. → DONE.
  - Shift/rotate, amt=0: no change, carry=0. → DONE. amt>0: → SHIFT.
- IDLE, op=NOP or op_go=0: stay IDLE.
- IDLE, op_go=1 and nLa=0 same edge: load wins, op_go ignored, no done.
- SHIFT: each edge shifts target one bit, cnt−1; carry = bit moved out (SHL: old MSB; SHR: old LSB, zero fill; ROL: MSB→LSB and carry; ROR: LSB→MSB and carry). When cnt reaches 0 → DONE.
- DONE: done=1, busy=1; next edge → IDLE.
- While busy: op_go ignored; nLa=0 with wsel≠target loads normally; nLa=0 with wsel=target ignored.
- aout, atemp, zero are combinational from reg[rsel] and nEa; reading the busy target shows intermediate values.

## Timing
- Load: value on atemp one edge after nLa sampled low.
- INC/DEC/CLEAR: result at edge E0 (go sampled); done=1 in cycle after E0; IDLE after E0+1. Next op_go accepted at E0+2.
- Shift amt=k>0: shifts at E1..Ek, done=1 in cycle after Ek, IDLE after Ek+1; total k+2 cycles from go to accept.
- amt=0: same timing as INC.
- amt=WIDTH: SHL/SHR yield 0; ROL/ROR restore the original value; carry = last bit moved.
- carry holds until next accepted op.

## Test plan
- Reset then load: CLR pulse mid-cycle → all regs 0, zero=1; nLa=0, ain=0xAA, wsel=1, rsel=1 → atemp=0xAA, aout=0xAA with nEa=0, aout=Z with nEa=1.
- INC wrap: reg0=0xFF, op=INC go → reg0=0x00, carry=1, zero=1, done one cycle after go; DEC on 0x00 → 0xFF, carry=1.
- SHL amt=3 on 0xB1 → busy 4 cycles, result 0x88, carry=1; ROR amt=8 on 0x5A → 0x5A, carry=0, done after 9 cycles.
- Contention: go and nLa same edge → load wins, no done; during SHIFT on reg0, load reg1=0x3C succeeds, load reg0 ignored, second op_go ignored.
- Reset mid-shift: CLR during SHIFT → busy=0 immediately, regs 0, no done ever pulses.
- amt=0 SHR → value unchanged, carry=0, done one cycle after go.
